posted_store_buffer: RTL and testbench
======================================

# posted_store_buffer

Parametrised posted-write buffer between the MEMPREP-stage load/store unit and the slow external memory and peripheral controllers, such as the SRAM controller. Stores are accepted in one cycle and drained in order through a trigger/busy handshake, so the pipeline no longer stalls for the full duration of every slow write. Loads are checked against pending stores: an exact match is forwarded from the buffer, and any other overlap is flagged so the core stalls.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 32, address width
- DATA_W, 32, data width
- FWD_EN, 1, 1 enables load forwarding; 0 turns every word match into a conflict
- clk  in  1  core clock; the only clock
- cpu_rst  in  1  reset, asynchronous and active-low
- st_valid  in  1  store request
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data, right-aligned
- st_width  in  2  00 byte, 01 half, 10 word
- st_ready  out  1  entry available; a push happens when st_valid & st_ready
- ld_valid  in  1  load lookup request
- ld_addr  in  ADDR_W  load byte address
- ld_width  in  2  same encoding as st_width
- ld_hit  out  1  forwardable match
- ld_data  out  DATA_W  forwarded data, raw with no extension; 0 when ld_hit=0
- ld_conflict  out  1  non-forwardable overlap; the core must stall
- mem_trigger  out  1  one-cycle write start pulse
- mem_addr  out  ADDR_W  head entry address
- mem_data  out  DATA_W  head entry data
- mem_width  out  2  head entry width
- mem_busy  in  1  controller busy, already synchronised to clk
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count==0; used as a fence indicator

## Operation
- **Storage:** circular FIFO with head/tail pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and pointers wrap modulo DEPTH.
- **Ready and count:**
  - st_ready = count<DEPTH; a pop in the same cycle does not raise it.
  - count is exact under simultaneous push and pop: it stays unchanged.
  - A push while full is ignored and leaves no state change.
- **Lookup** is combinational and applies only while ld_valid=1; otherwise ld_hit, ld_conflict and ld_data are 0.
  - Candidates are the valid entries plus the incoming store when st_valid & st_ready. The incoming store is the youngest candidate.
  - A candidate matches when its word address (addr[ADDR_W-1:2]) equals ld_addr's.
  - Youngest matching candidate has exact addr and width equal to the load, and FWD_EN=1 → ld_hit=1, ld_data = that candidate's data masked to the load width.
  - Any other match → ld_conflict=1.
  - No match → both 0.
  - ld_hit and ld_conflict are never 1 together.
- **Drain FSM** has four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE → ISSUE when !empty & !mem_busy.
  - ISSUE: mem_trigger=1 for exactly this cycle; next state is WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when mem_busy=1.
  - WAIT_DONE → IDLE when mem_busy=0; the head is popped on that edge.
- **mem outputs:** mem_addr, mem_data and mem_width always present the head entry. They hold stable from ISSUE through WAIT_DONE, because the head does not move until the pop.
- **Reset** (cpu_rst=0, at any time including mid-drain):
  - pointers and count clear to 0, FSM goes to IDLE;
  - all outputs go to 0 except st_ready=1 and empty=1;
  - the in-flight write is abandoned, as the controller is reset by the same reset.

## Timing
- A push at edge N is visible to lookup from cycle N onward: through the bypass before the edge, from storage after it.
- Empty buffer, mem_busy=0, push at edge N: ISSUE during cycle N+1, mem_trigger high in cycle N+1 only.
- Pop occurs on the first edge where WAIT_DONE samples mem_busy=0. Back-to-back entries therefore have a minimum spacing of 4 cycles between trigger pulses, plus the controller's busy time.
- Reset assertion takes effect immediately, without waiting for clk; deassertion is sampled on the next rising clk edge.
- Lookup outputs are combinational from ld_* and st_* inputs and from registered state; there is no registered latency.

## Test plan
- **Reset:** assert cpu_rst=0 mid-simulation → count=0, empty=1, st_ready=1, mem_trigger=0, ld_hit=0, ld_conflict=0.
- **Single drain:** push word 0x12345678 @0x9004; mem_busy rises 2 cycles after trigger and is held for 5 cycles → exactly one mem_trigger pulse with mem_addr=0x9004, mem_data=0x12345678, mem_width=10; pop on the first edge with mem_busy=0; empty=1 after that edge.
- **Fill and order:** DEPTH=4, mem_busy held high, push 0x9000/0x9004/0x9008/0x900C → st_ready=0 after the 4th push and a 5th push is ignored. Release busy → triggers in order 0x9000…0x900C; count decrements to 0.
- **Forwarding:** pending word 0xCAFEBABE @0x9010. Load word @0x9010 → ld_hit=1, ld_data=0xCAFEBABE. Load byte @0x9011 → ld_conflict=1. Load word @0x9014 → both 0. With FWD_EN=0, load word @0x9010 → ld_conflict=1.
- **Youngest wins and bypass:** word 0xAA @0x9020 pending; in the same cycle as st_valid=1 storing 0xBB @0x9020, look up @0x9020 → ld_hit=1, ld_data=0xBB. On the next cycle, with the buffer still undrained, ld_data=0xBB.
- **Reset mid-drain:** assert reset while in WAIT_DONE with 3 entries pending → immediate clear; after deassertion with mem_busy=0, no trigger is issued until a new push.

Source files
------------

// File: rtl/posted_store_buffer.sv
// Posted-write buffer between the load/store unit and slow memory/peripheral
// controllers. Stores are accepted in one cycle and drained in order through
// a trigger/busy handshake. Loads are checked against the pending stores:
// an exact match is forwarded, and any other overlap is flagged as a conflict.
module posted_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FWD_EN = 1
) (
  input  logic                       clk,
  input  logic                       cpu_rst,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [1:0]                 st_width,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [1:0]                 ld_width,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_conflict,
  output logic                       mem_trigger,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [1:0]                 mem_width,
  input  logic                       mem_busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W-1:0]  occupancy;
  logic              full;
  logic              push, pop;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [1:0]        width_mem [DEPTH];

  // Keep only the bytes the load asks for; data is right-aligned.
  function automatic logic [DATA_W-1:0] mask_width(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        w);
    logic [DATA_W-1:0] m;
    m = '1;
    case (w)
      2'b00:   m = DATA_W'(8'hFF);
      2'b01:   m = DATA_W'(16'hFFFF);
      default: m = '1;
    endcase
    return d & m;
  endfunction

  function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign occupancy = tail_q - head_q;
  assign count     = CNT_W'(occupancy);
  assign empty     = (head_q == tail_q);
  assign full      = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                     (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  assign st_ready  = !full;
  assign push      = st_valid && st_ready;

  // Head entry is shown to the controller; zero when nothing is pending.
  assign mem_addr  = empty ? '0 : addr_mem[head_q[IDX_W-1:0]];
  assign mem_data  = empty ? '0 : data_mem[head_q[IDX_W-1:0]];
  assign mem_width = empty ? '0 : width_mem[head_q[IDX_W-1:0]];

  // Pointer update: push advances tail, completed drain advances head.
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Entry storage write on push.
  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q[IDX_W-1:0]]  <= st_addr;
      data_mem[tail_q[IDX_W-1:0]]  <= st_data;
      width_mem[tail_q[IDX_W-1:0]] <= st_width;
    end
  end

  // Load lookup: walk oldest to youngest so the youngest match wins, with the
  // incoming store treated as younger than everything stored.
  always_comb begin
    logic              found;
    logic              exact;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  idx;
    // NOTE: every variable gets a default first so no latch is inferred.
    found       = 1'b0;
    exact       = 1'b0;
    sel_data    = '0;
    idx         = '0;
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q[IDX_W-1:0] + IDX_W'(k);
      if ((PTR_W'(k) < occupancy) && word_match(addr_mem[idx], ld_addr)) begin
        found    = 1'b1;
        exact    = (addr_mem[idx] == ld_addr) && (width_mem[idx] == ld_width);
        sel_data = data_mem[idx];
      end
    end
    if (push && word_match(st_addr, ld_addr)) begin
      found    = 1'b1;
      exact    = (st_addr == ld_addr) && (st_width == ld_width);
      sel_data = st_data;
    end
    if (ld_valid && cpu_rst && found) begin
      if (exact && (FWD_EN != 0)) begin
        ld_hit  = 1'b1;
        ld_data = mask_width(sel_data, ld_width);
      end else begin
        ld_conflict = 1'b1;
      end
    end
  end

  // Drain FSM state register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && !mem_busy) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (mem_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!mem_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Drain FSM outputs: trigger pulse and head pop at write completion.
  always_comb begin
    mem_trigger = (state_q == ISSUE);
    pop         = (state_q == WAIT_DONE) && !mem_busy;
  end

endmodule

// File: tb/tb_posted_store_buffer.sv
// Directed bench for posted_store_buffer: reset, single drain, fill/order,
// forwarding and conflicts, youngest-wins bypass, and reset mid-drain.
module tb_posted_store_buffer;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_width;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_width;
  logic        mem_busy;

  logic        st_ready, ld_hit, ld_conflict, mem_trigger, empty;
  logic [31:0] ld_data, mem_addr, mem_data;
  logic [1:0]  mem_width;
  logic [2:0]  count;

  logic        n_st_ready, n_ld_hit, n_ld_conflict, n_mem_trigger, n_empty;
  logic [31:0] n_ld_data, n_mem_addr, n_mem_data;
  logic [1:0]  n_mem_width;
  logic [2:0]  n_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr [4];

  posted_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .FWD_EN(1)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_width(st_width),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_width(ld_width),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .mem_trigger(mem_trigger), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_width(mem_width), .mem_busy(mem_busy),
    .count(count), .empty(empty)
  );

  // Same stimulus, forwarding disabled: only its lookup outputs are checked.
  posted_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .cpu_rst(cpu_rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_width(st_width),
    .st_ready(n_st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_width(ld_width),
    .ld_hit(n_ld_hit), .ld_data(n_ld_data), .ld_conflict(n_ld_conflict),
    .mem_trigger(n_mem_trigger), .mem_addr(n_mem_addr), .mem_data(n_mem_data),
    .mem_width(n_mem_width), .mem_busy(mem_busy),
    .count(n_count), .empty(n_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_width = w;
    step();
    st_valid = 1'b0;
  endtask

  task automatic wait_trig(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step();
      if (mem_trigger) seen = 1'b1;
    end
  endtask

  // Acts as a controller: busy for two cycles after each trigger, checks order.
  task automatic drain(input int n);
    int got      = 0;
    int busy_cnt = 0;
    for (int cyc = 0; cyc < 200 && !(got == n && empty); cyc++) begin
      if (mem_trigger) begin
        if (got < n) begin
          check("drain_addr", mem_addr, exp_addr[got]);
          check("drain_count", 32'(count), 32'(n - got));
        end
        got++;
        busy_cnt = 2;
      end
      mem_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
      step();
    end
    mem_busy = 1'b0;
    check("drain_triggers", 32'(got), 32'(n));
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic no_stray(input string tag);
    int stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_trigger) stray++;
    end
    check(tag, 32'(stray), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    cpu_rst  = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_width = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_width = '0;
    mem_busy = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_trigger", 32'(mem_trigger), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    cpu_rst = 1'b1;
    step();

    // Single drain
    push(32'h9004, 32'h12345678, 2'b10);
    wait_trig(4, seen);
    check("sd_trig_seen", 32'(seen), 32'd1);
    check("sd_addr", mem_addr, 32'h9004);
    check("sd_data", mem_data, 32'h12345678);
    check("sd_width", 32'(mem_width), 32'd2);
    step();
    check("sd_trig_one_cycle", 32'(mem_trigger), 32'd0);
    step();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sd_busy_no_trig", 32'(mem_trigger), 32'd0);
      check("sd_addr_stable", mem_addr, 32'h9004);
    end
    mem_busy = 1'b0;
    check("sd_not_popped_yet", 32'(empty), 32'd0);
    step();
    check("sd_popped_empty", 32'(empty), 32'd1);
    check("sd_popped_count", 32'(count), 32'd0);
    no_stray("sd_no_stray");

    // Fill and order
    mem_busy = 1'b1;
    push(32'h9000, 32'h11111111, 2'b10);
    push(32'h9004, 32'h22222222, 2'b10);
    push(32'h9008, 32'h33333333, 2'b10);
    check("fill_ready_3", 32'(st_ready), 32'd1);
    push(32'h900C, 32'h44444444, 2'b10);
    check("fill_ready_full", 32'(st_ready), 32'd0);
    check("fill_count_full", 32'(count), 32'd4);
    st_valid = 1'b1; st_addr = 32'h9100; st_data = 32'h55555555; st_width = 2'b10;
    ld_valid = 1'b1; ld_addr = 32'h9100; ld_width = 2'b10;
    #1;
    check("fill_no_bypass_full", 32'(ld_hit), 32'd0);
    step();
    st_valid = 1'b0; ld_valid = 1'b0;
    check("fill_ignored_count", 32'(count), 32'd4);
    check("fill_head_addr", mem_addr, 32'h9000);
    exp_addr[0] = 32'h9000; exp_addr[1] = 32'h9004;
    exp_addr[2] = 32'h9008; exp_addr[3] = 32'h900C;
    drain(4);
    no_stray("fill_no_stray");

    // Forwarding and conflicts
    mem_busy = 1'b1;
    push(32'h9010, 32'hCAFEBABE, 2'b10);
    push(32'h9030, 32'h1234ABCD, 2'b01);
    ld_valid = 1'b1; ld_addr = 32'h9010; ld_width = 2'b10;
    #1;
    check("fwd_hit", 32'(ld_hit), 32'd1);
    check("fwd_data", ld_data, 32'hCAFEBABE);
    check("fwd_no_conflict", 32'(ld_conflict), 32'd0);
    check("nofwd_conflict", 32'(n_ld_conflict), 32'd1);
    check("nofwd_hit", 32'(n_ld_hit), 32'd0);
    ld_addr = 32'h9011; ld_width = 2'b00;
    #1;
    check("byte_conflict", 32'(ld_conflict), 32'd1);
    check("byte_no_hit", 32'(ld_hit), 32'd0);
    check("byte_data_zero", ld_data, 32'd0);
    ld_addr = 32'h9014; ld_width = 2'b10;
    #1;
    check("miss_hit", 32'(ld_hit), 32'd0);
    check("miss_conflict", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h9030; ld_width = 2'b01;
    #1;
    check("half_hit", 32'(ld_hit), 32'd1);
    check("half_masked", ld_data, 32'h0000ABCD);
    ld_width = 2'b10;
    #1;
    check("half_vs_word_conflict", 32'(ld_conflict), 32'd1);
    ld_valid = 1'b0; ld_addr = 32'h9010;
    #1;
    check("ld_invalid_hit", 32'(ld_hit), 32'd0);

    // Youngest wins and bypass
    push(32'h9020, 32'h000000AA, 2'b10);
    st_valid = 1'b1; st_addr = 32'h9020; st_data = 32'h000000BB; st_width = 2'b10;
    ld_valid = 1'b1; ld_addr = 32'h9020; ld_width = 2'b10;
    #1;
    check("bypass_hit", 32'(ld_hit), 32'd1);
    check("bypass_data", ld_data, 32'h000000BB);
    step();
    st_valid = 1'b0;
    #1;
    check("young_hit", 32'(ld_hit), 32'd1);
    check("young_data", ld_data, 32'h000000BB);
    check("young_count", 32'(count), 32'd4);
    ld_valid = 1'b0;
    exp_addr[0] = 32'h9010; exp_addr[1] = 32'h9030;
    exp_addr[2] = 32'h9020; exp_addr[3] = 32'h9020;
    drain(4);

    // Reset mid-drain
    mem_busy = 1'b1;
    push(32'h9040, 32'hA0A0A0A0, 2'b10);
    push(32'h9044, 32'hB0B0B0B0, 2'b10);
    push(32'h9048, 32'hC0C0C0C0, 2'b10);
    mem_busy = 1'b0;
    wait_trig(4, seen);
    check("rmd_trig_seen", 32'(seen), 32'd1);
    mem_busy = 1'b1;
    step();
    step();
    check("rmd_count_pending", 32'(count), 32'd3);
    ld_valid = 1'b1; ld_addr = 32'h9044; ld_width = 2'b10;
    #1;
    check("rmd_hit_before", 32'(ld_hit), 32'd1);
    #2;
    cpu_rst = 1'b0;
    #1;
    check("rmd_count", 32'(count), 32'd0);
    check("rmd_empty", 32'(empty), 32'd1);
    check("rmd_ready", 32'(st_ready), 32'd1);
    check("rmd_trigger", 32'(mem_trigger), 32'd0);
    check("rmd_hit", 32'(ld_hit), 32'd0);
    check("rmd_conflict", 32'(ld_conflict), 32'd0);
    check("rmd_mem_addr", mem_addr, 32'd0);
    check("rmd_mem_data", mem_data, 32'd0);
    ld_valid = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    cpu_rst = 1'b1;
    no_stray("rmd_no_trigger_after");
    push(32'h9050, 32'hD0D0D0D0, 2'b10);
    exp_addr[0] = 32'h9050;
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
